// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared types and encodings for the multicycle MIPS controller: FSM state
// enum, opcode/funct values, ALU control codes and datapath mux encodings.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecute,
        StAluWb,
        StBranch,
        StAddiEx,
        StAddiWb,
        StJump
    } state_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake.
    function automatic logic is_mem_wait(input state_t s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// mips_alu_decoder
// Combinational R-type funct decode into an ALU control code plus a legality
// flag. Unsupported functs fall back to add so the datapath stays benign.
// Ports:
//   i_funct         instruction[5:0]
//   o_alu_control   ALU operation code
//   o_funct_legal   1 when i_funct is a supported R-type operation
// -----------------------------------------------------------------------------
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_legal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_legal = 1'b1;
        case (i_funct)
            FUNCT_ADD: o_alu_control = ALU_ADD;
            FUNCT_SUB: o_alu_control = ALU_SUB;
            FUNCT_AND: o_alu_control = ALU_AND;
            FUNCT_OR:  o_alu_control = ALU_OR;
            FUNCT_SLT: o_alu_control = ALU_SLT;
            default: begin
                o_alu_control = ALU_ADD;
                o_funct_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore controller for a multicycle MIPS datapath (shared memory, single ALU).
// Sequences lw/sw/R-type/beq/addi/j over 3-5 cycles and stalls on mem_ready.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_op, i_funct         instruction fields from the IR
//   i_zero                ALU zero flag (beq)
//   i_mem_ready           memory completed the current access this cycle
//   o_iord .. o_pc_src    datapath selects and write strobes
//   o_alu_control         ALU operation code
//   o_illegal             one-cycle pulse on unsupported op/funct
//   o_mem_err             sticky memory-wait timeout flag
// Parameters:
//   FETCH_TIMEOUT         wait cycles before o_mem_err is raised; 0 disables
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_pc_en,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_src,
    output logic [2:0] o_alu_control,
    output logic       o_illegal,
    output logic       o_mem_err
);

    state_t     r_state;
    logic       r_is_sw;
    logic [2:0] w_funct_alu;
    logic       w_funct_legal;
    logic       w_op_legal;
    logic       w_mem_err;

    mips_alu_decoder u_alu_decoder (
        .i_funct       (i_funct),
        .o_alu_control (w_funct_alu),
        .o_funct_legal (w_funct_legal)
    );

    always_comb begin
        w_op_legal = 1'b0;
        case (i_op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
            default:                                       w_op_legal = 1'b0;
        endcase
    end

    // State sequencing. r_is_sw remembers lw vs sw past DECODE so MEMADR
    // does not depend on the op field.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StFetch;
            r_is_sw <= 1'b0;
        end else begin
            case (r_state)
                StFetch: begin
                    if (i_mem_ready) r_state <= StDecode;
                end
                StDecode: begin
                    r_is_sw <= (i_op == OP_SW);
                    case (i_op)
                        OP_LW, OP_SW: r_state <= StMemAdr;
                        OP_RTYPE:     r_state <= StExecute;
                        OP_BEQ:       r_state <= StBranch;
                        OP_ADDI:      r_state <= StAddiEx;
                        OP_J:         r_state <= StJump;
                        default:      r_state <= StFetch;
                    endcase
                end
                StMemAdr:   r_state <= r_is_sw ? StMemWrite : StMemRead;
                StMemRead: begin
                    if (i_mem_ready) r_state <= StMemWb;
                end
                StMemWrite: begin
                    if (i_mem_ready) r_state <= StFetch;
                end
                StExecute:  r_state <= StAluWb;
                StAddiEx:   r_state <= StAddiWb;
                StMemWb, StAluWb, StBranch, StAddiWb, StJump: r_state <= StFetch;
                default:    r_state <= StFetch;
            endcase
        end
    end

    // Memory-wait watchdog. A stalled wait state never changes state, so
    // clearing whenever we are not stalled equals clearing on state change.
    if (FETCH_TIMEOUT > 0) begin : g_timeout
        localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 1);
        localparam logic [CntW-1:0] TimeoutVal = CntW'(FETCH_TIMEOUT);

        logic [CntW-1:0] r_wait_cnt;
        logic [CntW-1:0] w_wait_cnt_inc;
        logic            r_mem_err;
        logic            w_stalled;

        assign w_stalled      = is_mem_wait(r_state) && !i_mem_ready;
        assign w_wait_cnt_inc = r_wait_cnt + 1'b1;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_wait_cnt <= '0;
                r_mem_err  <= 1'b0;
            end else if (w_stalled) begin
                // Saturate so a long stall cannot wrap the counter.
                if (r_wait_cnt != TimeoutVal) r_wait_cnt <= w_wait_cnt_inc;
                if (w_wait_cnt_inc == TimeoutVal) r_mem_err <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end

        assign w_mem_err = r_mem_err;
    end else begin : g_no_timeout
        assign w_mem_err = 1'b0;
    end

    // Outputs decode from state; everything is forced low while in reset so
    // no strobe can glitch out of an abandoned instruction.
    always_comb begin
        o_iord        = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_en       = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_REG;
        o_pc_src      = PCSRC_ALU;
        o_alu_control = ALU_AND;
        o_illegal     = 1'b0;
        o_mem_err     = 1'b0;
        if (i_rst_n) begin
            o_mem_err = w_mem_err;
            case (r_state)
                StFetch: begin
                    o_alu_src_b   = SRCB_FOUR;
                    o_alu_control = ALU_ADD;
                    o_ir_write    = i_mem_ready;
                    o_pc_en       = i_mem_ready;
                end
                StDecode: begin
                    // Precompute branch target into ALUOut.
                    o_alu_src_b   = SRCB_IMM_SH2;
                    o_alu_control = ALU_ADD;
                    o_illegal     = !w_op_legal;
                end
                StMemAdr, StAddiEx: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = SRCB_IMM;
                    o_alu_control = ALU_ADD;
                end
                StMemRead: begin
                    o_iord = 1'b1;
                end
                StMemWb: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                end
                StMemWrite: begin
                    o_iord      = 1'b1;
                    o_mem_write = 1'b1;
                end
                StExecute: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = SRCB_REG;
                    o_alu_control = w_funct_alu;
                end
                StAluWb: begin
                    o_reg_dst   = 1'b1;
                    o_reg_write = w_funct_legal;
                    o_illegal   = !w_funct_legal;
                end
                StBranch: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = SRCB_REG;
                    o_alu_control = ALU_SUB;
                    o_pc_src      = PCSRC_ALUOUT;
                    o_pc_en       = i_zero;
                end
                StAddiWb: begin
                    o_reg_write = 1'b1;
                end
                StJump: begin
                    o_pc_src = PCSRC_JUMP;
                    o_pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed bench: each instruction is expanded into its list of micro-steps,
// a behavioural model gives the expected outputs for each step, and a
// negedge compare process checks every cycle. Literal checks pin key values.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       o_iord, o_mem_write, o_ir_write, o_pc_en, o_reg_dst, o_mem_to_reg;
    logic       o_reg_write, o_alu_src_a, o_illegal, o_mem_err;
    logic [1:0] o_alu_src_b, o_pc_src;
    logic [2:0] o_alu_control;

    mips_multicycle_ctrl #(.FETCH_TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_op          (op),
        .i_funct       (funct),
        .i_zero        (zero),
        .i_mem_ready   (mem_ready),
        .o_iord        (o_iord),
        .o_mem_write   (o_mem_write),
        .o_ir_write    (o_ir_write),
        .o_pc_en       (o_pc_en),
        .o_reg_dst     (o_reg_dst),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_reg_write   (o_reg_write),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_pc_src      (o_pc_src),
        .o_alu_control (o_alu_control),
        .o_illegal     (o_illegal),
        .o_mem_err     (o_mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal;
        logic       mem_err;
    } outv_t;

    typedef enum {
        MFetch, MDecode, MMemAdr, MMemRead, MMemWb, MMemWrite,
        MExec, MAluWb, MBranch, MAddiEx, MAddiWb, MJump
    } step_e;

    outv_t act;
    assign act = {o_iord, o_mem_write, o_ir_write, o_pc_en, o_reg_dst, o_mem_to_reg,
                  o_reg_write, o_alu_src_a, o_alu_src_b, o_pc_src, o_alu_control,
                  o_illegal, o_mem_err};

    step_e m_step = MFetch;
    int    m_wait = 0;
    logic  m_err = 1'b0;
    bit    chk_en = 1'b0;
    outv_t tr[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one micro-step, straight from the step table.
    function automatic outv_t model_out(input step_e s, input logic rst, input logic rdy,
                                        input logic z, input logic [5:0] o,
                                        input logic [5:0] f, input logic err);
        outv_t e = '0;
        if (!rst) return e;
        e.mem_err = err;
        case (s)
            MFetch: begin
                e.alu_src_b = 2'b01; e.alu_control = 3'b010;
                e.ir_write = rdy;    e.pc_en = rdy;
            end
            MDecode: begin
                e.alu_src_b = 2'b11; e.alu_control = 3'b010;
                e.illegal = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                        6'b001000, 6'b000010});
            end
            MMemAdr, MAddiEx: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
            end
            MMemRead:  e.iord = 1'b1;
            MMemWb:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
            MMemWrite: begin e.iord = 1'b1; e.mem_write = 1'b1; end
            MExec: begin
                e.alu_src_a = 1'b1; e.alu_control = funct_alu(f);
            end
            MAluWb: begin
                e.reg_dst = 1'b1; e.reg_write = funct_ok(f); e.illegal = !funct_ok(f);
            end
            MBranch: begin
                e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
            end
            MAddiWb:   e.reg_write = 1'b1;
            MJump:     begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("outputs in %s", m_step.name()), 32'(act),
                  32'(model_out(m_step, rst_n, mem_ready, zero, op, funct, m_err)));
            tr.push_back(act);
        end
    end

    // One clock of a given micro-step; also advances the timeout model.
    task automatic cycle(input step_e s, input logic rdy);
        m_step    = s;
        mem_ready = rdy;
        @(posedge clk);
        if (!rst_n) begin
            m_wait = 0;
            m_err  = 1'b0;
        end else if ((s == MFetch || s == MMemRead || s == MMemWrite) && !rdy) begin
            m_wait++;
            if (m_wait >= int'(TO)) m_err = 1'b1;
        end else begin
            m_wait = 0;
        end
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw);
        tr.delete();
        op = o; funct = f; zero = z;
        repeat (fw) cycle(MFetch, 1'b0);
        cycle(MFetch, 1'b1);
        cycle(MDecode, 1'b1);
        case (o)
            6'b100011: begin
                cycle(MMemAdr, 1'b1);
                repeat (mw) cycle(MMemRead, 1'b0);
                cycle(MMemRead, 1'b1);
                cycle(MMemWb, 1'b1);
            end
            6'b101011: begin
                cycle(MMemAdr, 1'b1);
                repeat (mw) cycle(MMemWrite, 1'b0);
                cycle(MMemWrite, 1'b1);
            end
            6'b000000: begin cycle(MExec, 1'b1); cycle(MAluWb, 1'b1); end
            6'b000100: cycle(MBranch, 1'b1);
            6'b001000: begin cycle(MAddiEx, 1'b1); cycle(MAddiWb, 1'b1); end
            6'b000010: cycle(MJump, 1'b1);
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [5:0] rf[4];
        logic [2:0] ra[4];
        int         n;
        rf = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
        ra = '{3'b010, 3'b000, 3'b001, 3'b111};

        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset all outputs zero", 32'(act), 32'd0);
        rst_n = 1'b1;

        // sub: FETCH, DECODE, EXECUTE, ALUWB
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        check("sub fetch ir_write", 32'(tr[0].ir_write), 32'd1);
        check("sub exec alu_control", 32'(tr[2].alu_control), 32'b110);
        check("sub aluwb reg_write,reg_dst", 32'({tr[3].reg_write, tr[3].reg_dst}), 32'b11);

        for (int i = 0; i < 4; i++) begin
            run_instr(6'b000000, rf[i], 1'b0, 0, 0);
            check($sformatf("rtype %b alu_control", rf[i]), 32'(tr[2].alu_control), 32'(ra[i]));
        end

        // lw with two not-ready cycles in MEMREAD
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
        n = 0;
        foreach (tr[i]) if (tr[i].reg_write) n++;
        check("lw single reg_write", 32'(n), 32'd1);
        check("lw cycle7 reg_write,mem_to_reg", 32'({tr[6].reg_write, tr[6].mem_to_reg}), 32'b11);
        check("lw memread iord", 32'(tr[3].iord), 32'd1);

        run_instr(6'b100011, 6'b000000, 1'b0, 1, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 1);
        check("sw mem_write held while stalled", 32'(tr[3].mem_write), 32'd1);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        check("addi writeback reg_dst=0", 32'({tr[3].reg_write, tr[3].reg_dst}), 32'b10);

        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        check("beq taken pc_en,pc_src", 32'({tr[2].pc_en, tr[2].pc_src}), 32'b101);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        check("beq not taken pc_en", 32'(tr[2].pc_en), 32'd0);

        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        check("jump pc_en,pc_src", 32'({tr[2].pc_en, tr[2].pc_src}), 32'b110);

        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        check("illegal op pulse", 32'(tr[1].illegal), 32'd1);
        check("illegal op no strobes",
              32'({tr[1].mem_write, tr[1].ir_write, tr[1].pc_en, tr[1].reg_write}), 32'd0);

        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
        check("illegal funct aluwb illegal,reg_write",
              32'({tr[3].illegal, tr[3].reg_write}), 32'b10);

        // Reset dropped in a stalled MEMWRITE, then a fetch stall trips the timeout.
        tr.delete();
        op = 6'b101011; funct = '0;
        cycle(MFetch, 1'b1);
        cycle(MDecode, 1'b1);
        cycle(MMemAdr, 1'b1);
        cycle(MMemWrite, 1'b0);
        cycle(MMemWrite, 1'b0);
        m_step = MMemWrite;
        mem_ready = 1'b0;
        check("mem_write before reset", 32'(act.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mem_write async drop", 32'(act.mem_write), 32'd0);
        check("outputs zero in reset", 32'(act), 32'd0);
        @(posedge clk);
        m_wait = 0;
        m_err  = 1'b0;
        #1;
        tr.delete();
        rst_n = 1'b1;
        repeat (6) cycle(MFetch, 1'b0);
        check("no write after reset", 32'({tr[0].mem_write, tr[0].reg_write}), 32'd0);
        check("mem_err low after 3 waits", 32'(tr[3].mem_err), 32'd0);
        check("mem_err set after 4 waits", 32'(tr[4].mem_err), 32'd1);
        check("mem_err sticky", 32'(tr[5].mem_err), 32'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS controller: a Moore FSM that sequences a shared-memory, single-ALU datapath over 3-5 cycles per instruction.
- Decodes op/funct, drives datapath mux selects and write strobes, and stalls on a memory-ready handshake.
- Sits beside the datapath in the multicycle core; replaces single-cycle decode.

Parameters:
- FETCH_TIMEOUT, 0, cycles to wait for mem_ready before raising mem_err; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26], from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted/returned the current access this cycle
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register load
- pc_en  out  1  PC load enable
- reg_dst  out  1  destination select: 1=rd, 0=rt
- mem_to_reg  out  1  writeback select: 1=Data, 0=ALUOut
- reg_write  out  1  register file write strobe
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B select: 00=B reg, 01=4, 10=SignImm, 11=SignImm<<2
- pc_src  out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse for an unsupported op or funct
- mem_err  out  1  sticky flag; cleared only by reset

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. Reset state is FETCH.
- Outputs are combinational from state plus mem_ready/zero/funct. All strobes (mem_write, ir_write, pc_en, reg_write) are 0 while rst_n=0. All selects default to 0 and illegal/mem_err are 0 in reset.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00. ir_write=pc_en=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target precompute). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op: illegal=1 for this cycle, next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEMWRITE: iord=1, mem_write=1. Hold (strobe stays high) until mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010, marked illegal.
- ALUWB: reg_dst=1, mem_to_reg=0. reg_write=1 only for a legal funct; an illegal funct gives illegal=1 and no write. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero; then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010; then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- JUMP: pc_src=10, pc_en=1; then FETCH.
- Latency with mem_ready tied high:
  - beq and j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
  - each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds 1.
- Timeout: if FETCH_TIMEOUT>0, a wait counter runs in any memory-wait state. When it reaches FETCH_TIMEOUT, mem_err is set; the FSM keeps waiting. The counter clears on each state change.
- Reset mid-instruction: immediate return to FETCH with strobes low. The in-flight instruction is abandoned and no partial write is issued after reset is released.
- op/funct are sampled only in DECODE/EXECUTE/ALUWB; the IR is stable then because ir_write is asserted only in FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state_t enum
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct localparams
  - ALU_ADD/SUB/AND/OR/SLT codes
  - alu_src_b and pc_src encodings
- Sub-module mips_alu_decoder: combinational funct -> {alu_control, funct_legal}, instantiated once.

Test Plan:
- Reset release, mem_ready=1, op=000000, funct=100010 -> states FETCH, DECODE, EXECUTE (alu_control=110), ALUWB (reg_write=1, reg_dst=1); back in FETCH at cycle 5.
- op=100011, mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles; a single reg_write pulse with mem_to_reg=1 at cycle 7.
- op=000100 with zero=1, then with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first; pc_en=0 in BRANCH for the second.
- op=000010 -> JUMP asserts pc_en=1, pc_src=10; 3-cycle instruction.
- op=111111 -> illegal pulses in DECODE, FETCH follows, no strobes. R-type with funct=000000 -> illegal in ALUWB and reg_write=0.
- rst_n dropped in MEMWRITE while mem_ready=0, with FETCH_TIMEOUT=4 and mem_ready held 0 in FETCH -> mem_write drops asynchronously and state=FETCH; after release, mem_err=1 following 4 wait cycles.
